// File: rtl/display_pkg.sv
// Shared definitions for the LCD frame arbiter and the display serializer.
package display_pkg;

    // Segment count of the LCD panel driven by the display serializer.
    localparam int DISPLAY_BITS = 72;

    // System clock frequency (CLK25MHZ domain).
    localparam int CLK_HZ = 25_000_000;

    // Arbiter control states.
    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } arb_state_e;

    // Width of a client index; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Client-side bus of the display arbiter: level requests with full frames in,
// capture acknowledges, ownership and the latched frame out.
interface display_arbiter_if #(
    parameter int NUM_CLIENTS  = 4,
    parameter int DISPLAY_BITS = display_pkg::DISPLAY_BITS
);

    logic [NUM_CLIENTS-1:0]              req;
    logic [NUM_CLIENTS*DISPLAY_BITS-1:0] frame_in;
    logic [NUM_CLIENTS-1:0]              ack;
    logic [NUM_CLIENTS-1:0]              grant;
    logic [DISPLAY_BITS-1:0]             display_bits;
    logic                                display_update;
    logic                                busy;

    // Frame producers drive requests and frames.
    modport master (
        output req, frame_in,
        input  ack, grant, display_bits, display_update, busy
    );

    // The arbiter consumes requests and reports ownership.
    modport slave (
        input  req, frame_in,
        output ack, grant, display_bits, display_update, busy
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin winner search: scans from ptr+1 upward (mod N)
// and returns the first requester as an index and as a one-hot vector.
module rr_picker
    import display_pkg::*;
#(
    parameter int NUM_CLIENTS = 4
) (
    input  logic [NUM_CLIENTS-1:0]                 req_i,
    input  logic [ptr_width(NUM_CLIENTS)-1:0]      ptr_i,
    output logic                                   valid_o,
    output logic [ptr_width(NUM_CLIENTS)-1:0]      idx_o,
    output logic [NUM_CLIENTS-1:0]                 onehot_o
);

    localparam int IDX_W = ptr_width(NUM_CLIENTS);

    logic found;

    // First requester after the last owner wins; the last owner itself is
    // visited last, giving it the lowest priority.
    always_comb begin
        found    = 1'b0;
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            int j;
            j = (int'(ptr_i) + k) % NUM_CLIENTS;
            if (!found && req_i[j]) begin
                found       = 1'b1;
                valid_o     = 1'b1;
                idx_o       = IDX_W'(j);
                onehot_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Shares the LCD between several frame producers. A round-robin winner's
// frame is latched into display_bits and the winner keeps ownership for a
// minimum dwell time; during dwell only the owner may refresh its frame.
module display_arbiter #(
    parameter int NUM_CLIENTS  = 4,
    parameter int DISPLAY_BITS = display_pkg::DISPLAY_BITS,
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    display_arbiter_if.slave  bus
);

    import display_pkg::*;

    localparam int IDX_W = ptr_width(NUM_CLIENTS);
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(NUM_CLIENTS - 1);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CLIENTS-1:0]  grant_q, grant_d;
    logic [NUM_CLIENTS-1:0]  ack_q, ack_d;
    logic [DISPLAY_BITS-1:0] bits_q, bits_d;
    logic                    upd_q, upd_d;

    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;
    logic [NUM_CLIENTS-1:0]  pick_onehot;
    logic [DISPLAY_BITS-1:0] win_frame;
    logic [DISPLAY_BITS-1:0] own_frame;
    logic                    owner_req;

    rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_picker (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    // Candidate frames: the arbitration winner and the current owner.
    always_comb begin
        win_frame = bus.frame_in[int'(pick_idx) * DISPLAY_BITS +: DISPLAY_BITS];
        own_frame = bus.frame_in[int'(ptr_q) * DISPLAY_BITS +: DISPLAY_BITS];
        owner_req = |(bus.req & grant_q);
    end

    // Next-state logic: arbitrate in IDLE, count down and allow owner refresh in DWELL.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        bits_d  = bits_q;
        ack_d   = '0;
        upd_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = DWELL;
                    ptr_d   = pick_idx;
                    grant_d = pick_onehot;
                    ack_d   = pick_onehot;
                    upd_d   = 1'b1;
                    bits_d  = win_frame;
                    cnt_d   = DWELL_LOAD;
                end
            end
            DWELL: begin
                // The final dwell cycle never captures, so the owner's
                // request there falls through to IDLE arbitration.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (owner_req) begin
                        ack_d  = grant_q;
                        upd_d  = 1'b1;
                        bits_d = own_frame;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset clears everything including the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RESET;
            cnt_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            upd_q   <= 1'b0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            upd_q   <= upd_d;
            bits_q  <= bits_d;
        end
    end

    assign bus.ack            = ack_q;
    assign bus.grant          = grant_q;
    assign bus.display_bits   = bits_q;
    assign bus.display_update = upd_q;
    assign bus.busy           = (state_q == DWELL);

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: a cycle-timeline model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_display_arbiter;

    localparam int N = 4;
    localparam int W = 72;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_arbiter_if #(.NUM_CLIENTS(N), .DISPLAY_BITS(W)) bus();

    display_arbiter #(
        .NUM_CLIENTS  (N),
        .DISPLAY_BITS (W),
        .DWELL_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    localparam logic [W-1:0] FR0  = 72'hA5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [W-1:0] FR1  = 72'h11_2233_4455_6677_8899;
    localparam logic [W-1:0] FR2A = 72'hC3_C3C3_C3C3_C3C3_C3C3;
    localparam logic [W-1:0] FR2B = 72'h0F_1E2D_3C4B_5A69_7887;
    localparam logic [W-1:0] FR3  = 72'hFE_DCBA_9876_5432_10FE;

    task automatic expect_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input int i, input logic [W-1:0] v);
        bus.frame_in[i*W +: W] = v;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        expect_eq(name, W'(bus.busy), '0);
    endtask

    // Timeline model: m_since counts edges since the last arbitration grant.
    // 1..D is ownership, D+1 and beyond is idle; refresh allowed for 1..D-1.
    int               m_since;
    int               m_ptr;
    int               m_w;
    bit               m_found;
    logic [N-1:0]     m_grant;
    logic [N-1:0]     m_ack;
    logic [W-1:0]     m_bits;
    logic             m_upd;

    always @(posedge clk) begin
        if (rst) begin
            m_since = D + 1;
            m_ptr   = N - 1;
            m_grant = '0;
            m_ack   = '0;
            m_bits  = '0;
            m_upd   = 1'b0;
        end else begin
            m_ack = '0;
            m_upd = 1'b0;
            if (m_since >= 1 && m_since < D) begin
                m_since++;
                if (bus.req[m_ptr]) begin
                    m_ack  = N'(1) << m_ptr;
                    m_upd  = 1'b1;
                    m_bits = bus.frame_in[m_ptr*W +: W];
                end
            end else if (m_since == D) begin
                m_since++;
            end else begin
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    m_w = (m_ptr + k) % N;
                    if (!m_found && bus.req[m_w]) begin
                        m_found = 1'b1;
                        m_ptr   = m_w;
                        m_grant = N'(1) << m_w;
                        m_ack   = N'(1) << m_w;
                        m_upd   = 1'b1;
                        m_bits  = bus.frame_in[m_w*W +: W];
                        m_since = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            expect_eq("cyc_ack",   W'(bus.ack),            W'(m_ack));
            expect_eq("cyc_grant", W'(bus.grant),          W'(m_grant));
            expect_eq("cyc_bits",  bus.display_bits,       m_bits);
            expect_eq("cyc_upd",   W'(bus.display_update), W'(m_upd));
            expect_eq("cyc_busy",  W'(bus.busy),
                      (m_since >= 1 && m_since <= D) ? W'(1) : W'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ng;
        int fall;
        int ackc;
        bit saw3;
        logic [N-1:0] last_g;
        logic [N-1:0] g_seq [5];
        int           g_cyc [5];

        bus.req      = '0;
        bus.frame_in = '0;
        set_frame(0, FR0);
        set_frame(1, FR1);
        set_frame(2, FR2A);
        set_frame(3, FR3);

        // Reset state
        rst = 1'b1;
        tick(2);
        chk_en = 1'b1;
        expect_eq("rst_bits",  bus.display_bits, '0);
        expect_eq("rst_grant", W'(bus.grant), '0);
        expect_eq("rst_ack",   W'(bus.ack), '0);
        expect_eq("rst_upd",   W'(bus.display_update), '0);
        expect_eq("rst_busy",  W'(bus.busy), '0);
        rst = 1'b0;

        // Single request after reset
        bus.req = 4'b0001;
        tick();
        expect_eq("t1_ack",   W'(bus.ack), W'(4'b0001));
        expect_eq("t1_upd",   W'(bus.display_update), W'(1));
        expect_eq("t1_bits",  bus.display_bits, FR0);
        expect_eq("t1_grant", W'(bus.grant), W'(4'b0001));
        bus.req = '0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy === 1'b1) cnt++;
            tick();
        end
        expect_eq("t1_busy_len", W'(cnt), W'(8));

        // All clients requesting continuously from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1111;
        ng = 0;
        last_g = bus.grant;
        for (int k = 0; k < 5; k++) begin
            g_seq[k] = '0;
            g_cyc[k] = 0;
        end
        for (int i = 1; i <= 60 && ng < 5; i++) begin
            tick();
            if (bus.grant !== last_g) begin
                g_seq[ng] = bus.grant;
                g_cyc[ng] = i;
                last_g    = bus.grant;
                ng++;
            end
        end
        expect_eq("rr_count", W'(ng), W'(5));
        expect_eq("rr_g0", W'(g_seq[0]), W'(4'b0001));
        expect_eq("rr_g1", W'(g_seq[1]), W'(4'b0010));
        expect_eq("rr_g2", W'(g_seq[2]), W'(4'b0100));
        expect_eq("rr_g3", W'(g_seq[3]), W'(4'b1000));
        expect_eq("rr_g4", W'(g_seq[4]), W'(4'b0001));
        expect_eq("rr_first", W'(g_cyc[0]), W'(1));
        for (int k = 1; k < 5; k++)
            expect_eq("rr_spacing", W'(g_cyc[k] - g_cyc[k-1]), W'(9));
        bus.req = '0;
        wait_idle("rr_idle_timeout");

        // Owner refresh during dwell
        bus.req = 4'b0100;
        tick();
        expect_eq("ref_ack0",  W'(bus.ack), W'(4'b0100));
        expect_eq("ref_bits0", bus.display_bits, FR2A);
        bus.req = '0;
        tick(2);
        set_frame(2, FR2B);
        bus.req = 4'b0100;
        tick();
        expect_eq("ref_ack1",  W'(bus.ack), W'(4'b0100));
        expect_eq("ref_bits1", bus.display_bits, FR2B);
        bus.req = '0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy === 1'b1) cnt++;
            tick();
        end
        expect_eq("ref_busy_rest", W'(cnt), W'(5));

        // Non-owner request during dwell waits for the bubble cycle
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        tick();
        bus.req = 4'b0010;
        fall = -1;
        ackc = -1;
        for (int i = 1; i <= 30 && ackc < 0; i++) begin
            tick();
            if (bus.busy === 1'b0 && fall < 0) fall = i;
            if (bus.ack !== '0 && ackc < 0) begin
                ackc    = i;
                bus.req = '0;
            end
        end
        bus.req = '0;
        expect_eq("nonown_fall",  W'(fall), W'(7));
        expect_eq("nonown_delay", W'(ackc - fall), W'(1));
        expect_eq("nonown_grant", W'(bus.grant), W'(4'b0010));

        // Withdrawn request and idle hold
        bus.req = 4'b1000;
        saw3 = 1'b0;
        tick(2);
        bus.req = '0;
        for (int i = 0; i < 30; i++) begin
            if (bus.ack[3] === 1'b1) saw3 = 1'b1;
            tick();
        end
        expect_eq("wd_no_ack",     W'(saw3), '0);
        expect_eq("wd_hold_grant", W'(bus.grant), W'(4'b0010));
        expect_eq("wd_hold_bits",  bus.display_bits, FR1);

        // Reset in the middle of dwell
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        tick(3);
        rst = 1'b1;
        tick();
        expect_eq("mrst_bits",  bus.display_bits, '0);
        expect_eq("mrst_grant", W'(bus.grant), '0);
        expect_eq("mrst_ack",   W'(bus.ack), '0);
        expect_eq("mrst_upd",   W'(bus.display_update), '0);
        expect_eq("mrst_busy",  W'(bus.busy), '0);
        rst = 1'b0;
        bus.req = 4'b1111;
        tick();
        expect_eq("mrst_grant0", W'(bus.grant), W'(4'b0001));
        expect_eq("mrst_bits0",  bus.display_bits, FR0);
        bus.req = '0;
        wait_idle("end_idle_timeout");
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
